// File: rtl/dm_20x10.sv
// Signed 20x10 combinational multiplier; returns the exact 30-bit two's-complement product.
module dm_20x10 (
    input  logic signed [19:0] in1_i,
    input  logic signed [9:0]  in2_i,
    output logic signed [29:0] prod_o
);

    assign prod_o = in1_i * in2_i;

endmodule

// File: rtl/mul_arb_20x10.sv
// Two-requester round-robin front end sharing one dm_20x10 through a two-stage
// valid/ready pipeline (operand register S1, product register S2).
module mul_arb_20x10 (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [19:0] a_IN1,
    input  logic [9:0]  a_IN2,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [19:0] b_IN1,
    input  logic [9:0]  b_IN2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [29:0] out_result,
    output logic        out_id,
    output logic [15:0] op_count
);

    logic        s1_valid_q, s1_id_q, prio_q;
    logic [19:0] s1_in1_q, s1_in1_d;
    logic [9:0]  s1_in2_q, s1_in2_d;
    logic        out_valid_q, out_id_q;
    logic [29:0] out_result_q;
    logic [15:0] op_count_q;
    logic [29:0] prod;
    logic        adv1, adv2, grant_a, grant_b, accept;

    dm_20x10 u_dm (
        .in1_i  (s1_in1_q),
        .in2_i  (s1_in2_q),
        .prod_o (prod)
    );

    always_comb begin
        adv2     = !out_valid_q || out_ready;
        adv1     = !s1_valid_q || adv2;
        // prio selects only on contention; a lone requester always wins.
        grant_a  = a_valid && (!b_valid || !prio_q);
        grant_b  = b_valid && (!a_valid || prio_q);
        a_ready  = adv1 && grant_a && !rst;
        b_ready  = adv1 && grant_b && !rst;
        accept   = a_ready || b_ready;
        s1_in1_d = b_ready ? b_IN1 : a_IN1;
        s1_in2_d = b_ready ? b_IN2 : a_IN2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_id_q      <= 1'b0;
            prio_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_id_q     <= 1'b0;
            out_result_q <= '0;
            op_count_q   <= '0;
        end else begin
            if (adv1) begin
                s1_valid_q <= accept;
                if (accept) begin
                    s1_id_q <= b_ready;
                    prio_q  <= a_ready;
                end
            end
            if (adv2) begin
                out_valid_q <= s1_valid_q;
                // Product register only moves on real data so stale operands never show.
                if (s1_valid_q) begin
                    out_result_q <= prod;
                    out_id_q     <= s1_id_q;
                end
            end
            if (out_valid_q && out_ready) begin
                op_count_q <= op_count_q + 16'd1;
            end
        end
    end

    // Operand registers carry no reset; they are qualified by s1_valid_q.
    always_ff @(posedge clk) begin
        if (adv1 && accept) begin
            s1_in1_q <= s1_in1_d;
            s1_in2_q <= s1_in2_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_id     = out_id_q;
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_mul_arb_20x10.sv
// Randomized bench for mul_arb_20x10 against a queue-based behavioural model of the arbiter.
module tb_mul_arb_20x10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_valid = 1'b0, b_valid = 1'b0, out_ready = 1'b0;
    logic [19:0] a_IN1 = '0, b_IN1 = '0;
    logic [9:0]  a_IN2 = '0, b_IN2 = '0;
    logic        a_ready, b_ready, out_valid, out_id;
    logic [29:0] out_result;
    logic [15:0] op_count;

    always #5 clk = ~clk;

    mul_arb_20x10 dut (
        .clk        (clk),
        .rst        (rst),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .a_IN1      (a_IN1),
        .a_IN2      (a_IN2),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_IN1      (b_IN1),
        .b_IN2      (b_IN2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_id     (out_id),
        .op_count   (op_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [29:0] ref_prod(input logic [19:0] x, input logic [9:0] y);
        int sx, sy, p;
        sx = int'($signed(x));
        sy = int'($signed(y));
        p  = sx * sy;
        return p[29:0];
    endfunction

    // Model: in-flight products in acceptance order, each with its age in cycles.
    // The head is visible once two cycles old; the two-slot pipe takes a new pair
    // whenever it holds fewer than two or the consumer is draining it.
    typedef struct {
        logic [29:0] p;
        logic        id;
        int          age;
    } item_t;

    item_t       q[$];
    bit          m_prio = 1'b0;
    logic [15:0] m_cnt = '0;
    int          m_total = 0;
    bit          started = 1'b0;
    bit          e_acc_a = 1'b0, e_acc_b = 1'b0, e_deliver = 1'b0;
    logic [29:0] e_prod = '0;

    always @(negedge clk) begin
        if (started) begin
            bit can, ga, gb, ea, eb, ov;
            can = (q.size() < 2) || out_ready;
            ga  = a_valid && (!b_valid || !m_prio);
            gb  = b_valid && (!a_valid || m_prio);
            ea  = !rst && can && ga;
            eb  = !rst && can && gb;
            ov  = (q.size() > 0) && (q[0].age >= 2);
            chk("a_ready", 32'(a_ready), 32'(ea));
            chk("b_ready", 32'(b_ready), 32'(eb));
            chk("out_valid", 32'(out_valid), 32'(ov));
            chk("op_count", 32'(op_count), 32'(m_cnt));
            if (ov) begin
                chk("out_result", 32'(out_result), 32'(q[0].p));
                chk("out_id", 32'(out_id), 32'(q[0].id));
            end
            e_acc_a   = ea;
            e_acc_b   = eb;
            e_deliver = ov && out_ready;
            e_prod    = eb ? ref_prod(b_IN1, b_IN2) : ref_prod(a_IN1, a_IN2);
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_prio  = 1'b0;
            m_cnt   = '0;
            m_total = 0;
            started = 1'b1;
        end else if (started) begin
            if (e_deliver) begin
                void'(q.pop_front());
                m_cnt++;
                m_total++;
            end
            foreach (q[i]) q[i].age++;
            if (e_acc_a || e_acc_b) begin
                q.push_back('{p: e_prod, id: e_acc_b, age: 1});
                m_prio = e_acc_a;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ops();
        a_IN1 = 20'($urandom);
        a_IN2 = 10'($urandom);
        b_IN1 = 20'($urandom);
        b_IN2 = 10'($urandom);
    endtask

    initial begin
        logic [3:0] ids;
        bit         done;

        rst = 1'b1;
        repeat (3) cyc();
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_op_count", 32'(op_count), 32'h0);
        chk("rst_out_result", 32'(out_result), 32'h0);
        chk("rst_out_id", 32'(out_id), 32'h0);
        chk("rst_a_ready", 32'(a_ready), 32'h0);
        rst = 1'b0;

        // -1 * -1 from A alone.
        out_ready = 1'b1;
        a_valid = 1'b1; a_IN1 = 20'hFFFFF; a_IN2 = 10'h3FF;
        #1 chk("a_only_ready", 32'(a_ready), 32'h1);
        cyc(); a_valid = 1'b0;
        cyc();
        chk("neg1_valid", 32'(out_valid), 32'h1);
        chk("neg1_result", 32'(out_result), 32'h1);
        chk("neg1_id", 32'(out_id), 32'h0);
        cyc();
        chk("neg1_count", 32'(op_count), 32'h1);

        // Extreme operand corners.
        a_valid = 1'b1; a_IN1 = 20'h80000; a_IN2 = 10'h200;
        cyc(); a_IN1 = 20'h7FFFF; a_IN2 = 10'h1FF;
        cyc(); a_valid = 1'b0;
        chk("min_min_result", 32'(out_result), 32'h1000_0000);
        cyc();
        chk("max_max_result", 32'(out_result), 32'd267910657);
        cyc();

        // Both requesters held from reset: alternation A,B,A,B.
        rst = 1'b1; cyc(); rst = 1'b0;
        rand_ops();
        a_valid = 1'b1; b_valid = 1'b1;
        cyc(); cyc();
        for (int i = 0; i < 4; i++) begin
            chk("alt_valid", 32'(out_valid), 32'h1);
            ids[i] = out_id;
            cyc();
        end
        chk("alt_ids", 32'(ids), 32'b1010);

        // Consumer stall with both valid: pipe already full, so readys drop at once.
        out_ready = 1'b0;
        #1 chk("stall_a_ready", 32'(a_ready), 32'h0);
        chk("stall_b_ready", 32'(b_ready), 32'h0);
        repeat (5) cyc();
        out_ready = 1'b1;
        repeat (4) cyc();

        // One-cycle reset with both stages full.
        out_ready = 1'b0;
        cyc();
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("mid_rst_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_count", 32'(op_count), 32'h0);
        #1 chk("mid_rst_grant_a", 32'(a_ready), 32'h1);
        chk("mid_rst_grant_b", 32'(b_ready), 32'h0);
        out_ready = 1'b1;
        repeat (3) cyc();

        // 65536 handshakes wrap op_count back to zero.
        rst = 1'b1; cyc(); rst = 1'b0;
        out_ready = 1'b1; a_valid = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 70000 && !done; i++) begin
            rand_ops();
            b_valid = 1'($urandom);
            cyc();
            if (m_total == 65536) done = 1'b1;
        end
        chk("wrap_reached", 32'(done), 32'h1);
        chk("wrap_op_count", 32'(op_count), 32'h0);

        // Fully random traffic including backpressure and occasional resets.
        for (int i = 0; i < 4000; i++) begin
            rand_ops();
            if ($urandom_range(0, 9) == 0) begin
                a_IN1 = ($urandom_range(0, 1) != 0) ? 20'h80000 : 20'h7FFFF;
                b_IN2 = ($urandom_range(0, 1) != 0) ? 10'h200 : 10'h1FF;
            end
            a_valid   = ($urandom_range(0, 3) != 0);
            b_valid   = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            rst       = ($urandom_range(0, 199) == 0);
            cyc();
        end
        rst = 1'b0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_arb_20x10.md
MUL_ARB_20X10 -- requirements
Module: mul_arb_20x10

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 a_valid  input  1  requester A holds a valid operand pair.
REQ-005 a_ready  output  1  requester A pair accepted this cycle.
REQ-006 a_IN1  input  20  requester A multiplicand, signed two's complement.
REQ-007 a_IN2  input  10  requester A multiplier, signed two's complement.
REQ-008 b_valid, b_ready, b_IN1, b_IN2  same directions, widths and meanings as the A ports, for requester B.
REQ-009 out_valid  output  1  out_result holds a valid product.
REQ-010 out_ready  input  1  consumer accepts the product this cycle.
REQ-011 out_result  output  30  signed product IN1*IN2.
REQ-012 out_id  output  1  source of the product: 0 = A, 1 = B.
REQ-013 op_count  output  16  count of completed output handshakes.

Function
REQ-014 SHALL contain exactly one dm_20x10 instance, shared by both requesters. There SHALL be no other multiply logic.
REQ-015 Pipeline stages:
- S1: operand register holding s1_valid, s1_id, IN1 and IN2.
- S2: output register holding out_valid, out_id and out_result.
REQ-016 The dm_20x10 inputs SHALL be driven only from the S1 registers. Its 30-bit output SHALL be captured into out_result.
REQ-017 Definitions:
- adv2 = !out_valid | out_ready (S2 can load).
- adv1 = !s1_valid | adv2 (S1 can load).
REQ-018 Arbitration SHALL be round-robin with a 1-bit priority pointer prio (0 = A favoured). It SHALL grant:
- the only valid requester, when exactly one requester is valid;
- the requester indicated by prio, when both are valid.
REQ-019 a_ready = adv1 & grant_A; b_ready = adv1 & grant_B. At most one ready SHALL be high in any cycle. A ready SHALL never be high while its valid is low.
REQ-020 On an accepted request:
- S1 SHALL load the operands and id, and set s1_valid.
- prio SHALL become the non-granted requester.
REQ-021 If adv1 is high and no request is accepted, s1_valid SHALL clear.
REQ-022 If adv2 is high:
- S2 SHALL load the dm_20x10 product and s1_id.
- out_valid SHALL become s1_valid.
REQ-023 Latency: a request accepted in cycle t SHALL give out_valid=1 in cycle t+2 with its product.
REQ-024 Throughput SHALL be one product per cycle while out_ready=1.
REQ-025 While out_valid=1 and out_ready=0:
- out_result and out_id SHALL hold stable.
- S1 SHALL hold.
- Both readys SHALL drop once S1 is full.
REQ-026 Products SHALL leave in acceptance order. None SHALL be dropped or duplicated.
REQ-027 out_result SHALL equal the exact 30-bit two's-complement product for all input pairs, including -524288 * -512.
REQ-028 op_count SHALL increment by 1 on each cycle with out_valid & out_ready. It SHALL wrap from 0xFFFF to 0x0000.
REQ-029 A requester holding valid SHALL be granted within 2 accepting cycles (no starvation).

Reset
REQ-030 Reset SHALL force: s1_valid=0, out_valid=0, prio=0, op_count=0, out_id=0, out_result=0.
REQ-031 While rst=1, a_ready=0 and b_ready=0.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight products. No out_valid SHALL appear for them after reset releases.
REQ-033 Operand registers MAY retain their value through reset. Their contents SHALL NOT affect any output while s1_valid=0.

Verification
REQ-034 A only, a_IN1=-1 (0xFFFFF), a_IN2=-1 (0x3FF), out_ready=1 -> out_valid at t+2, out_result=1, out_id=0, op_count=1.
REQ-035 A only, a_IN1=-524288, a_IN2=-512 -> out_result=0x10000000. Then a_IN1=524287, a_IN2=511 -> out_result=267910657.
REQ-036 Both valid and held from the first cycle after reset, out_ready=1 -> grants alternate A,B,A,B; out_id sequence 0,1,0,1; one product per cycle.
REQ-037 out_ready=0 for 5 cycles with both valid:
- S2 holds its first product.
- S1 fills, then both readys go low.
- On release, outputs arrive in acceptance order with no loss.
REQ-038 Assert rst for 1 cycle while S1 and S2 are full -> next cycle out_valid=0, op_count=0, prio=0; the following grant with both valid goes to A.
REQ-039 Run 65536 output handshakes -> op_count reads 0x0000. Random signed operands are checked against a reference product.
